aes_cipher_core: RTL and testbench

Iterative AES forward cipher (encryption): consumes a 128-bit plaintext block and a pre-expanded key schedule, and produces the 128-bit ciphertext after Nr round cycles. It is the encrypt-side counterpart of the existing inverse cipher and uses the same key-schedule bus layout and state byte ordering, so both directions share one key expander. Input and output use valid/ready handshakes so the block sits directly between a block-mode controller and an output FIFO.

---
 rtl/aes_pkg.sv | 80 ++++++++
 rtl/aes_enc_round.sv | 59 +++++
 rtl/aes_cipher_core.sv | 128 ++++++++++++
 tb/tb_aes_cipher_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES definitions for the forward and inverse cipher
//               cores: FSM state encoding, forward/inverse S-box lookups,
//               GF(2^8) arithmetic, AddRoundKey and the state byte-index
//               helper.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : none (package)
// ============================================================================
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // S-box tables packed as 256 bytes, entry 0 at the MSBs.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by {02} modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    return s ^ k;
  endfunction

  // MSB position of state byte (row r, column c); columns are stored
  // column-major with byte 0 at the top of the 128-bit word.
  function automatic int byte_msb(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_enc_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_round
// Description : One combinational AES encryption round:
//               SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
//               MixColumns is bypassed on the final round.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : state_in    [127:0] round input state
//               round_key   [127:0] key added at the end of the round
//               final_round         skip MixColumns when high
//               state_out   [127:0] round output state
// ============================================================================
module aes_enc_round (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);
  import aes_pkg::*;

  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;

  // Column transform with circulant {02,03,01,01}; byte 0 at the MSBs.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ gf_mul(s1, 8'h03) ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ gf_mul(s2, 8'h03) ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ gf_mul(s3, 8'h03),
            gf_mul(s0, 8'h03) ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  always_comb begin
    sub_bytes  = '0;
    shift_rows = '0;
    mix_cols   = '0;
    for (int k = 0; k < 16; k++) begin
      sub_bytes[127 - 8 * k -: 8] = sbox_fwd(state_in[127 - 8 * k -: 8]);
    end
    // Row r rotates left by r columns.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        shift_rows[byte_msb(r, c) -: 8] = sub_bytes[byte_msb(r, (c + r) % 4) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_cols[127 - 32 * c -: 32] = mix_column(shift_rows[127 - 32 * c -: 32]);
    end
    state_out = add_round_key(final_round ? shift_rows : mix_cols, round_key);
  end

endmodule : aes_enc_round
`default_nettype wire

// File: rtl/aes_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : aes_cipher_core
// Description : Iterative AES forward cipher. One round per clock using a
//               single aes_enc_round instance; the expanded key schedule is
//               supplied externally and must stay stable while a block is
//               in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk, rst               clock / async active-high reset
//               in_valid, in_ready     plaintext handshake
//               data_in   [127:0]      plaintext, byte 0 at MSBs
//               w [(Nr+1)*128-1:0]     expanded key, round 0 at MSBs
//               out_valid, out_ready   ciphertext handshake
//               data_out  [127:0]      ciphertext
//               busy                   high while a block is in flight
// ============================================================================
module aes_cipher_core #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          data_in,
  input  logic [(Nr+1)*128-1:0] w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          data_out,
  output logic                  busy
);
  import aes_pkg::*;

  localparam int         KEY_BITS = (Nr + 1) * 128;
  localparam logic [3:0] LAST_RND = 4'(Nr);

  // Named scope marks an inconsistent Nk/Nr pairing in the elaborated
  // hierarchy; the datapath itself only depends on Nr.
  if (Nr != Nk + 6) begin : g_cfg_mismatch
  end

  aes_fsm_e     fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] data_out_q, data_out_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] rk0;
  logic [127:0] rk_rnd;
  logic [127:0] round_out;
  logic         final_round;

  assign rk0         = w[KEY_BITS-1 -: 128];
  assign final_round = (rnd_q == LAST_RND);

  // Round-key mux; rnd is only 1..Nr while it is used.
  always_comb begin
    rk_rnd = rk0;
    for (int r = 1; r <= Nr; r++) begin
      if (rnd_q == 4'(r)) rk_rnd = w[KEY_BITS-1-r*128 -: 128];
    end
  end

  aes_enc_round u_round (
    .state_in    (state_q),
    .round_key   (rk_rnd),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = add_round_key(data_in, rk0);
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (final_round) begin
          data_out_d  = round_out;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      state_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q != IDLE);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule : aes_cipher_core
`default_nettype wire

// File: tb/tb_aes_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_cipher_core
// Description : Directed FIPS-197 vectors for the AES-128 and AES-256
//               configurations of aes_cipher_core, covering latency,
//               backpressure, back-to-back blocks, busy-time input noise and
//               mid-block reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_cipher_core;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT_C128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0]  a_data_in, a_data_out;
  logic [1407:0] a_w;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0]  b_data_in, b_data_out;
  logic [1919:0] b_w;

  logic [1407:0] wk_b, wk_c;
  logic [1919:0] wk_256;

  int n_cmp = 0;
  int n_bad = 0;

  aes_cipher_core #(.Nk(4), .Nr(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data_in), .w(a_w), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .data_out(a_data_out), .busy(a_busy)
  );

  aes_cipher_core #(.Nk(8), .Nr(14)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .w(b_w), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .data_out(b_data_out), .busy(b_busy)
  );

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {aes_pkg::sbox_fwd(x[31:24]), aes_pkg::sbox_fwd(x[23:16]),
            aes_pkg::sbox_fwd(x[15:8]),  aes_pkg::sbox_fwd(x[7:0])};
  endfunction

  // FIPS-197 key expansion; key words taken from the MSBs, schedule word 0
  // placed at bit 1919.
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] bus;
    int            nw;
    nw  = 4 * (nk + 7);
    rc  = 8'h01;
    bus = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) bus[1919 - 32 * i -: 32] = wd[i];
    return bus;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_hold_in_ready: got %b want 1", a_in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_data_out !== 128'h0) begin n_bad++; $display("FAIL reset_a_data_out: got %h want 0", a_data_out); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
    n_cmp++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_b: got ov=%b ir=%b busy=%b want 0 1 0", b_out_valid, b_in_ready, b_busy);
    end
  endtask

  task automatic test_fips_b;
    int lat;
    a_w = wk_b; a_data_in = PT_B; a_out_ready = 1'b1; a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
      n_bad++; $display("FAIL fipsb_accept: got ir=%b busy=%b want 0 1", a_in_ready, a_busy);
    end
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL fipsb_latency: got %0d want 10", lat); end
    n_cmp++; if (a_data_out !== CT_B) begin n_bad++; $display("FAIL fipsb_data: got %h want %h", a_data_out, CT_B); end
    @(negedge clk);
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL fipsb_handshake: got ov=%b ir=%b want 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_aes256;
    int lat;
    b_w = wk_256; b_data_in = PT_C; b_out_ready = 1'b1; b_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (b_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL aes256_latency: got %0d want 14", lat); end
    n_cmp++; if (b_data_out !== CT_C256) begin n_bad++; $display("FAIL aes256_data: got %h want %h", b_data_out, CT_C256); end
  endtask

  task automatic test_backpressure;
    int lat;
    a_w = wk_c; a_data_in = PT_C; a_out_ready = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL c128_latency: got %0d want 10", lat); end
    n_cmp++; if (a_data_out !== CT_C128) begin n_bad++; $display("FAIL c128_data: got %h want %h", a_data_out, CT_C128); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_data_out !== CT_C128) begin
        n_bad++; $display("FAIL stall_cycle%0d: got ov=%b ir=%b data=%h want 1 0 %h", i, a_out_valid, a_in_ready, a_data_out, CT_C128);
      end
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_release: got ir=%b ov=%b want 1 0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2, n;
    a_w = wk_c; a_data_in = PT_C; a_out_ready = 1'b1; a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    t1 = cyc;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (a_data_out !== CT_C128 || a_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first: got ov=%b data=%h want 1 %h", a_out_valid, a_data_out, CT_C128);
    end
    a_w = wk_b; a_data_in = PT_B;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (a_in_ready !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    t2 = cyc;
    a_in_valid = 1'b0;
    n_cmp++; if (t2 - t1 !== 12) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 12", t2 - t1); end
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (a_data_out !== CT_B || a_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second: got ov=%b data=%h want 1 %h", a_out_valid, a_data_out, CT_B);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_input;
    int lat, extra;
    a_w = wk_b; a_data_in = PT_B; a_out_ready = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    lat = 0; extra = 0;
    while (a_out_valid !== 1'b1 && lat < 40) begin
      if (a_in_ready !== 1'b0) extra++;
      a_in_valid = ~a_in_valid;
      a_data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk); lat++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL busy_extra_ready: got %0d want 0", extra); end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL busy_latency: got %0d want 10", lat); end
    n_cmp++; if (a_data_out !== CT_B) begin n_bad++; $display("FAIL busy_data: got %h want %h", a_data_out, CT_B); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL busy_release: got %b want 1", a_in_ready); end
  endtask

  task automatic test_reset_mid;
    int lat;
    a_w = wk_c; a_data_in = PT_C; a_out_ready = 1'b1; a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_data_out !== 128'h0) begin n_bad++; $display("FAIL midrst_data_out: got %h want 0", a_data_out); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", a_busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", a_in_ready); end
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_partial_output: got %b want 0", a_out_valid); end
    a_w = wk_b; a_data_in = PT_B; a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL midrst_next_latency: got %0d want 10", lat); end
    n_cmp++; if (a_data_out !== CT_B) begin n_bad++; $display("FAIL midrst_next_data: got %h want %h", a_data_out, CT_B); end
  endtask

  initial begin
    logic [1919:0] tmp;
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_data_in = '0; a_w = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_data_in = '0; b_w = '0;
    tmp    = expand_key(KEY_B, 4);    wk_b = tmp[1919 -: 1408];
    tmp    = expand_key(KEY_C128, 4); wk_c = tmp[1919 -: 1408];
    wk_256 = expand_key(KEY_C256, 8);

    test_reset();
    test_fips_b();
    test_aes256();
    test_backpressure();
    test_back_to_back();
    test_busy_input();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule : tb_aes_cipher_core
`default_nettype wire
